nb_scan_sequencer: RTL and testbench

- Sequences the narrowband wake-up DSP through a scan of stored wake-up templates.
- For each enabled template: selects the LUT entry (R_SEL), pulses READ to reload the correlator coefficients, and releases the FFT from reset (FFT_RUN drives the DSP's active-low reset).
- Waits for DATA_READY with a timeout, evaluates WAKEUP, and raises a sticky interrupt on a match.
- Sits between the SPI configuration registers and the DSP / WUS LUT, replacing direct pad control of START_FFT and the READ/R_SEL nets.

---
 rtl/nb_scan_sequencer.sv | 167 ++++++++++++++++
 tb/tb_nb_scan_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nb_scan_sequencer.sv
// Scan sequencer for the narrowband wake-up DSP: walks the enabled LUT templates,
// strobes the coefficient reload, runs the FFT and latches wake-up / timeout events.
module nb_scan_sequencer #(
    parameter int NUM_TEMPLATES = 12,
    parameter int SEL_W         = 4,
    parameter int TIMEOUT_W     = 16,
    parameter int PERIOD_W      = 20
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ENABLE,
    input  logic [NUM_TEMPLATES-1:0] TEMPLATE_MASK,
    input  logic [7:0]               SETTLE,
    input  logic [TIMEOUT_W-1:0]     TIMEOUT,
    input  logic [PERIOD_W-1:0]      SCAN_PERIOD,
    input  logic                     DATA_READY,
    input  logic                     WAKEUP,
    input  logic                     IRQ_CLR,
    output logic [SEL_W-1:0]         R_SEL,
    output logic                     READ,
    output logic                     FFT_RUN,
    output logic                     WAKE_IRQ,
    output logic [SEL_W-1:0]         MATCH_IDX,
    output logic                     TIMEOUT_ERR,
    output logic                     BUSY,
    output logic [15:0]              SCAN_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_NEXT,
        S_WAIT_PERIOD
    } state_t;

    state_t                   state, next_state;
    logic [NUM_TEMPLATES-1:0] shadow_mask;
    logic [SEL_W-1:0]         idx, next_idx;
    logic [SEL_W-1:0]         lowest_idx, above_idx;
    logic                     next_found;
    logic [7:0]               settle_cnt;
    logic [TIMEOUT_W-1:0]     run_timer;
    logic [PERIOD_W-1:0]      period_cnt;
    logic [15:0]              scan_cnt;
    logic                     start, match, timed_out, scan_done;
    logic                     read_d, fft_run_d, busy_d;

    assign R_SEL      = idx;
    assign SCAN_COUNT = scan_cnt;

    // Priority encoders: first template of a new scan, and next template above idx.
    always_comb begin
        lowest_idx = '0;
        above_idx  = '0;
        next_found = 1'b0;
        for (int i = NUM_TEMPLATES - 1; i >= 0; i--) begin
            if (TEMPLATE_MASK[i]) lowest_idx = SEL_W'(i);
            if (shadow_mask[i] && (i > int'(idx))) begin
                above_idx  = SEL_W'(i);
                next_found = 1'b1;
            end
        end
    end

    assign start     = ENABLE && !WAKE_IRQ && (TEMPLATE_MASK != '0);
    assign match     = (state == S_RUN) && ENABLE && DATA_READY && WAKEUP;
    assign timed_out = (state == S_RUN) && ENABLE && !DATA_READY && (TIMEOUT != '0)
                       && (run_timer == TIMEOUT - TIMEOUT_W'(1));
    assign scan_done = (state == S_NEXT) && ENABLE && !next_found;

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        next_idx   = idx;
        if ((state != S_IDLE) && !ENABLE) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        next_state = S_LOAD;
                        next_idx   = lowest_idx;
                    end
                end
                S_LOAD:   next_state = (SETTLE == 8'd0) ? S_RUN : S_SETTLE;
                S_SETTLE: if (settle_cnt == 8'd1) next_state = S_RUN;
                S_RUN: begin
                    if (DATA_READY && WAKEUP)
                        next_state = (SCAN_PERIOD == '0) ? S_IDLE : S_WAIT_PERIOD;
                    else if (DATA_READY || timed_out)
                        next_state = S_NEXT;
                end
                S_NEXT: begin
                    if (next_found) begin
                        next_state = S_LOAD;
                        next_idx   = above_idx;
                    end else begin
                        next_state = (SCAN_PERIOD == '0) ? S_IDLE : S_WAIT_PERIOD;
                    end
                end
                S_WAIT_PERIOD: if (period_cnt == PERIOD_W'(1)) next_state = S_IDLE;
                default:  next_state = S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the upcoming state so they register in step with it.
    always_comb begin
        read_d    = (next_state == S_LOAD);
        fft_run_d = (next_state == S_RUN);
        busy_d    = (next_state != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx         <= '0;
            shadow_mask <= '0;
            settle_cnt  <= '0;
            run_timer   <= '0;
            period_cnt  <= '0;
        end else begin
            idx <= next_idx;
            if ((state == S_IDLE) && (next_state == S_LOAD)) shadow_mask <= TEMPLATE_MASK;
            if (state == S_LOAD)        settle_cnt <= SETTLE;
            else if (state == S_SETTLE) settle_cnt <= settle_cnt - 8'd1;
            if (state == S_RUN) run_timer <= run_timer + TIMEOUT_W'(1);
            else                run_timer <= '0;
            if ((next_state == S_WAIT_PERIOD) && (state != S_WAIT_PERIOD))
                period_cnt <= SCAN_PERIOD;
            else if (state == S_WAIT_PERIOD)
                period_cnt <= period_cnt - PERIOD_W'(1);
        end
    end

    // Sticky flags: a same-cycle set beats IRQ_CLR.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            READ        <= 1'b0;
            FFT_RUN     <= 1'b0;
            BUSY        <= 1'b0;
            WAKE_IRQ    <= 1'b0;
            MATCH_IDX   <= '0;
            TIMEOUT_ERR <= 1'b0;
            scan_cnt    <= '0;
        end else begin
            READ    <= read_d;
            FFT_RUN <= fft_run_d;
            BUSY    <= busy_d;
            if (match) begin
                WAKE_IRQ  <= 1'b1;
                MATCH_IDX <= idx;
            end else if (IRQ_CLR) begin
                WAKE_IRQ <= 1'b0;
            end
            if (timed_out)    TIMEOUT_ERR <= 1'b1;
            else if (IRQ_CLR) TIMEOUT_ERR <= 1'b0;
            if (scan_done && (scan_cnt != 16'hFFFF)) scan_cnt <= scan_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_nb_scan_sequencer.sv
// Bench for nb_scan_sequencer: a DSP responder model, a READ-order scoreboard and
// a table of whole-scan vectors, plus hand-written abort / mask / IRQ / saturation sequences.
module tb_nb_scan_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, ENABLE;
    logic [11:0] TEMPLATE_MASK;
    logic [7:0]  SETTLE;
    logic [15:0] TIMEOUT;
    logic [19:0] SCAN_PERIOD;
    logic        DATA_READY, WAKEUP, IRQ_CLR;
    logic        main_clr, dsp_clr;
    logic [3:0]  R_SEL, MATCH_IDX;
    logic        READ, FFT_RUN, WAKE_IRQ, TIMEOUT_ERR, BUSY;
    logic [15:0] SCAN_COUNT;

    typedef struct {
        logic [11:0] mask;
        int          settle;
        int          timeout;
        int          period;
        int          dr;
        int          wake;
        bit          exp_wake;
        int          exp_match;
        bit          exp_terr;
        int          exp_inc;
    } vec_t;

    vec_t vecs[5];
    int   read_q[$];
    int   n_checks = 0, n_errors = 0;
    int   cycle = 0, exp_count = 0;
    int   cfg_settle = 0, cfg_timeout = 0, cfg_dr = 0, cfg_wake = -1;
    bit   cfg_abort = 1'b0, cfg_clr_on_match = 1'b0;
    int   last_read = 0, last_fall = 0, run_len = 0, dsp_cnt = 0;
    logic prev_fft = 1'b0;

    assign IRQ_CLR = main_clr | dsp_clr;

    nb_scan_sequencer dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .TEMPLATE_MASK(TEMPLATE_MASK),
        .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .SCAN_PERIOD(SCAN_PERIOD),
        .DATA_READY(DATA_READY), .WAKEUP(WAKEUP), .IRQ_CLR(IRQ_CLR),
        .R_SEL(R_SEL), .READ(READ), .FFT_RUN(FFT_RUN), .WAKE_IRQ(WAKE_IRQ),
        .MATCH_IDX(MATCH_IDX), .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY),
        .SCAN_COUNT(SCAN_COUNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    function automatic int expLen();
        if (cfg_dr != 0 && (cfg_timeout == 0 || cfg_dr <= cfg_timeout)) return cfg_dr;
        return cfg_timeout;
    endfunction

    // Drives the config inputs and pushes the template order the scan should visit.
    task automatic applyStimulus(input vec_t v);
        TEMPLATE_MASK = v.mask;
        SETTLE        = 8'(v.settle);
        TIMEOUT       = 16'(v.timeout);
        SCAN_PERIOD   = 20'(v.period);
        cfg_settle    = v.settle;
        cfg_timeout   = v.timeout;
        cfg_dr        = v.dr;
        cfg_wake      = v.wake;
        for (int i = 0; i < 12; i++) begin
            if (v.mask[i]) begin
                read_q.push_back(i);
                if (i == v.wake) break;
            end
        end
    endtask

    task automatic waitScan(input int period, input bit wake, input bit stop);
        int n;
        n = 0;
        while (BUSY !== 1'b1 && n < 50) begin tick(); n++; end
        checkOutput("busy_rise", BUSY, 1);
        n = 0;
        while (BUSY === 1'b1 && n < 5000) begin tick(); n++; end
        if (BUSY !== 1'b0) checkOutput("busy_fall_timeout", BUSY, 0);
        else checkOutput("busy_drop_delay", cycle - last_fall, period + (wake ? 0 : 1));
        if (stop) ENABLE = 1'b0;
    endtask

    // DSP model: one DATA_READY pulse cfg_dr cycles into each RUN window.
    initial begin
        DATA_READY = 1'b0;
        WAKEUP     = 1'b0;
        dsp_clr    = 1'b0;
        forever begin
            @(negedge CLK);
            DATA_READY = 1'b0;
            WAKEUP     = 1'b0;
            dsp_clr    = 1'b0;
            if (FFT_RUN === 1'b1) begin
                dsp_cnt++;
                if (cfg_dr != 0 && dsp_cnt == cfg_dr) begin
                    DATA_READY = 1'b1;
                    WAKEUP     = (int'(R_SEL) == cfg_wake);
                    dsp_clr    = cfg_clr_on_match && WAKEUP;
                end
            end else begin
                dsp_cnt = 0;
            end
        end
    end

    // Monitor: READ order against the scoreboard, READ-to-FFT_RUN latency, RUN length.
    initial begin
        forever begin
            @(negedge CLK);
            if (READ === 1'b1) begin
                if (read_q.size() == 0) checkOutput("unexpected_read", READ, 0);
                else checkOutput("read_rsel", R_SEL, read_q.pop_front());
                last_read = cycle;
            end
            if (FFT_RUN === 1'b1) begin
                if (prev_fft !== 1'b1) checkOutput("fft_delay", cycle - last_read, cfg_settle + 1);
                run_len++;
            end else if (prev_fft === 1'b1) begin
                last_fall = cycle;
                if (!cfg_abort) checkOutput("run_len", run_len, expLen());
                run_len = 0;
            end
            prev_fft = FFT_RUN;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        bit  seen;
        vecs[0] = '{12'h005, 3, 100, 10, 20, -1, 1'b0, 0,  1'b0, 1};
        vecs[1] = '{12'h0F0, 2, 50,  5,  4,  5,  1'b1, 5,  1'b0, 0};
        vecs[2] = '{12'h001, 0, 8,   3,  0,  -1, 1'b0, 0,  1'b1, 1};
        vecs[3] = '{12'h801, 1, 0,   0,  3,  11, 1'b1, 11, 1'b0, 0};
        vecs[4] = '{12'h0A0, 5, 4,   2,  10, -1, 1'b0, 0,  1'b1, 1};

        RESET = 1'b1; ENABLE = 1'b0; main_clr = 1'b0;
        TEMPLATE_MASK = '0; SETTLE = '0; TIMEOUT = '0; SCAN_PERIOD = '0;
        tick(); tick(); tick();
        checkOutput("reset_strobes", {READ, FFT_RUN, BUSY}, 0);
        checkOutput("reset_flags", {WAKE_IRQ, TIMEOUT_ERR}, 0);
        checkOutput("reset_sel", {R_SEL, MATCH_IDX}, 0);
        checkOutput("reset_count", SCAN_COUNT, 0);
        RESET = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) begin
            applyStimulus(vecs[k]);
            ENABLE = 1'b1;
            waitScan(vecs[k].period, vecs[k].exp_wake, 1'b1);
            tick();
            exp_count += vecs[k].exp_inc;
            checkOutput("wake_irq", WAKE_IRQ, vecs[k].exp_wake);
            if (vecs[k].exp_wake) checkOutput("match_idx", MATCH_IDX, vecs[k].exp_match);
            checkOutput("timeout_err", TIMEOUT_ERR, vecs[k].exp_terr);
            checkOutput("scan_count", SCAN_COUNT, exp_count);
            checkOutput("reads_left", read_q.size(), 0);
            main_clr = 1'b1; tick(); main_clr = 1'b0;
            checkOutput("flags_cleared", {WAKE_IRQ, TIMEOUT_ERR}, 0);
            checkOutput("busy_idle", BUSY, 0);
        end

        // ENABLE dropped mid-SETTLE, then mid-RUN; each restart begins at template 2.
        applyStimulus('{12'h00C, 6, 0, 2, 0, -1, 1'b0, 0, 1'b0, 0});
        read_q.delete();
        read_q.push_back(2);
        cfg_abort = 1'b1;
        ENABLE = 1'b1;
        tick(); tick(); tick();
        ENABLE = 1'b0;
        tick();
        checkOutput("abort_settle", {BUSY, FFT_RUN, READ}, 0);
        tick(); tick(); tick();
        read_q.push_back(2);
        ENABLE = 1'b1;
        n = 0;
        while (FFT_RUN !== 1'b1 && n < 20) begin tick(); n++; end
        checkOutput("fft_run_start", FFT_RUN, 1);
        tick(); tick();
        ENABLE = 1'b0;
        tick();
        checkOutput("abort_run", {BUSY, FFT_RUN, READ}, 0);
        checkOutput("abort_reads_left", read_q.size(), 0);
        checkOutput("abort_count_kept", SCAN_COUNT, exp_count);
        cfg_abort = 1'b0;
        tick();

        // Mask change mid-scan only takes effect on the following scan.
        applyStimulus('{12'h003, 2, 0, 4, 5, -1, 1'b0, 0, 1'b0, 0});
        ENABLE = 1'b1;
        tick(); tick(); tick();
        TEMPLATE_MASK = 12'h800;
        read_q.push_back(11);
        waitScan(4, 1'b0, 1'b0);
        waitScan(4, 1'b0, 1'b1);
        tick();
        exp_count += 2;
        checkOutput("mask_change_count", SCAN_COUNT, exp_count);
        checkOutput("mask_change_reads_left", read_q.size(), 0);

        TEMPLATE_MASK = 12'h000;
        ENABLE = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); seen |= BUSY; end
        checkOutput("empty_mask_idle", seen, 0);
        ENABLE = 1'b0;
        tick();

        // IRQ_CLR coincident with the match: the set must win and block restart.
        applyStimulus('{12'h010, 1, 0, 3, 2, 4, 1'b1, 4, 1'b0, 0});
        cfg_clr_on_match = 1'b1;
        ENABLE = 1'b1;
        waitScan(3, 1'b1, 1'b0);
        checkOutput("wake_set_wins", WAKE_IRQ, 1);
        checkOutput("wake_match_idx", MATCH_IDX, 4);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin tick(); seen |= BUSY; end
        checkOutput("no_restart_while_irq", seen, 0);
        cfg_clr_on_match = 1'b0;
        cfg_wake = -1;
        read_q.push_back(4);
        main_clr = 1'b1; tick(); main_clr = 1'b0;
        waitScan(3, 1'b0, 1'b1);
        tick();
        exp_count++;
        checkOutput("restart_count", SCAN_COUNT, exp_count);
        checkOutput("restart_wake_clear", WAKE_IRQ, 0);
        checkOutput("match_idx_retained", MATCH_IDX, 4);

        // Saturation of the scan counter.
        force dut.scan_cnt = 16'hFFFE;
        #1;
        release dut.scan_cnt;
        exp_count = 16'hFFFE;
        checkOutput("count_preload", SCAN_COUNT, exp_count);
        for (int s = 0; s < 2; s++) begin
            applyStimulus('{12'h001, 0, 0, 1, 1, -1, 1'b0, 0, 1'b0, 1});
            ENABLE = 1'b1;
            waitScan(1, 1'b0, 1'b1);
            tick();
            if (exp_count != 16'hFFFF) exp_count++;
            checkOutput("count_saturate", SCAN_COUNT, exp_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
